// File: rtl/mat_mem_arbiter.sv
// Two-requester arbiter for a single-port matrix RAM with locked bursts and range checking.
// Optional `ARB_ROUND_ROBIN_EN selects round-robin contention; default is fixed priority to r0.
module mat_mem_arbiter #(
  parameter int unsigned DW        = 8,
  parameter int unsigned M         = 8,
  parameter int unsigned N         = 8,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned AW       = M + N + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_err,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_err,
  output logic          mem_ramEN,
  output logic          mem_writeEN,
  output logic          mem_readEN,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int unsigned CW     = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_BURST);
  localparam logic [AW-1:0] Depth  = AW'(M * N);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] burst_q, burst_d;
  logic [1:0]    rd_q, rd_d;
  logic [1:0]    oor_rd_q, oor_rd_d;
  logic [1:0]    oor_wr_q, oor_wr_d;
  logic [DW-1:0] hold0_q, hold1_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic          ptr_q, ptr_d;
`endif

  logic r0_oor, r1_oor;
  logic [CW-1:0] burst_inc;

  assign r0_oor    = (r0_addr >= Depth);
  assign r1_oor    = (r1_addr >= Depth);
  assign burst_inc = (burst_q == MaxCnt) ? burst_q : burst_q + CW'(1);

  // Arbitration and ownership
  always_comb begin
    r0_gnt  = 1'b0;
    r1_gnt  = 1'b0;
    state_d = state_q;
    burst_d = burst_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        burst_d = '0;
        if (r0_req && r1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          r0_gnt = ~ptr_q;
          r1_gnt = ptr_q;
          ptr_d  = ~ptr_q;
`else
          r0_gnt = 1'b1;
`endif
        end else begin
          r0_gnt = r0_req;
          r1_gnt = r1_req;
        end
        if (r0_gnt && r0_lock) begin
          state_d = StOwn0;
          burst_d = CW'(1);
        end else if (r1_gnt && r1_lock) begin
          state_d = StOwn1;
          burst_d = CW'(1);
        end
      end
      StOwn0: begin
        if (r0_req && !(burst_q == MaxCnt && r1_req)) begin
          r0_gnt = 1'b1;
          if (r0_lock) begin
            burst_d = burst_inc;
          end else begin
            state_d = StIdle;
            burst_d = '0;
          end
        end else begin
          // Owner idle or forced out: the cycle goes to the waiting requester.
          r1_gnt  = r1_req;
          state_d = StIdle;
          burst_d = '0;
        end
      end
      StOwn1: begin
        if (r1_req && !(burst_q == MaxCnt && r0_req)) begin
          r1_gnt = 1'b1;
          if (r1_lock) begin
            burst_d = burst_inc;
          end else begin
            state_d = StIdle;
            burst_d = '0;
          end
        end else begin
          r0_gnt  = r0_req;
          state_d = StIdle;
          burst_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        burst_d = '0;
      end
    endcase
  end

  // RAM port mux; out-of-range grants never touch the RAM
  always_comb begin
    mem_ramEN   = 1'b0;
    mem_writeEN = 1'b0;
    mem_readEN  = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    if (r0_gnt && !r0_oor) begin
      mem_ramEN   = 1'b1;
      mem_writeEN = r0_we;
      mem_readEN  = ~r0_we;
      mem_addr    = r0_addr;
      mem_din     = r0_wdata;
    end else if (r1_gnt && !r1_oor) begin
      mem_ramEN   = 1'b1;
      mem_writeEN = r1_we;
      mem_readEN  = ~r1_we;
      mem_addr    = r1_addr;
      mem_din     = r1_wdata;
    end
  end

  always_comb begin
    rd_d     = {r1_gnt & ~r1_we & ~r1_oor, r0_gnt & ~r0_we & ~r0_oor};
    oor_rd_d = {r1_gnt & ~r1_we &  r1_oor, r0_gnt & ~r0_we &  r0_oor};
    oor_wr_d = {r1_gnt &  r1_we &  r1_oor, r0_gnt &  r0_we &  r0_oor};
  end

  // Read data passes straight from the RAM in the response cycle, otherwise holds
  always_comb begin
    r0_rdata  = rd_q[0] ? mem_dout : (oor_rd_q[0] ? '0 : hold0_q);
    r1_rdata  = rd_q[1] ? mem_dout : (oor_rd_q[1] ? '0 : hold1_q);
    r0_rvalid = rd_q[0] | oor_rd_q[0];
    r1_rvalid = rd_q[1] | oor_rd_q[1];
    r0_err    = oor_rd_q[0] | oor_wr_q[0];
    r1_err    = oor_rd_q[1] | oor_wr_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      burst_q  <= '0;
      rd_q     <= '0;
      oor_rd_q <= '0;
      oor_wr_q <= '0;
      hold0_q  <= '0;
      hold1_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      rd_q     <= rd_d;
      oor_rd_q <= oor_rd_d;
      oor_wr_q <= oor_wr_d;
      hold0_q  <= r0_rdata;
      hold1_q  <= r1_rdata;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

endmodule
